// File: rtl/ara_test_harness_if.sv
// ara_test_harness_if: APB bus between the SoC console UART port (master)
// and the harness UART sink (slave).
//   paddr/psel/penable/pwrite/pwdata : request, driven by the master
//   prdata/pready/pslverr             : response, driven by the slave
interface ara_test_harness_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/ara_test_harness.sv
// ara_test_harness: simulation top around the Ara SoC.
//   clk_i  : single clock, rising edge
//   rst_i  : synchronous active-high reset (the SoC gets its inverse)
//   exit_o : SoC exit word, bit0 = end of test, bits 63:1 = tohost code
// Measures runtime and CVA6 stall statistics over the window in which
// software holds hw_cnt_en[0] high, and sinks the SoC console UART.
// The modules ahead of the top form a behavioural stand-in of ara_soc
// that keeps the hierarchy the bench reaches by name; its registers idle
// at their reset values unless a bench overrides them.

// Row-organised memory with a fixed response latency. init_val holds the
// preload image, one DataWidth row per entry.
module ara_mem_model #(
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 128,
  parameter int unsigned          NumRows   = 16,
  parameter int unsigned          RespDelay = 200,
  parameter logic [AddrWidth-1:0] Base      = '0,
  parameter logic [AddrWidth-1:0] Length    = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 hit_o,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o
);
  localparam int unsigned RowShift = $clog2(DataWidth / 8);
  localparam int unsigned IdxWidth = $clog2(NumRows);
  // Delay is given in ps; round up to whole 1 ns cycles, at least one.
  localparam int unsigned DelayCycles = (RespDelay + 999) / 1000 > 0 ?
                                        (RespDelay + 999) / 1000 : 1;

  logic [DataWidth-1:0]   init_val [NumRows];
  logic [AddrWidth-1:0]   offset;
  logic [DelayCycles-1:0] vld_q, vld_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;

  assign offset = addr_i - Base;
  assign hit_o  = (addr_i >= Base) && (offset < Length);

  // Data is captured at request time; only the valid flag travels down the
  // delay line, so back-to-back requests return the most recent row.
  always_comb begin
    vld_d   = DelayCycles'({vld_q, req_i & hit_o});
    rdata_d = rdata_q;
    if (req_i && hit_o) begin
      rdata_d = init_val[offset[RowShift +: IdxWidth]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q   <= '0;
      rdata_q <= '0;
    end else begin
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
    end
  end

  assign rvalid_o = vld_q[DelayCycles-1];
  assign rdata_o  = rdata_q;
endmodule

// Vector load unit stand-in: while triggered, sweeps one vector register's
// worth of rows starting at BaseAddr and folds the responses together.
module ara_vlsu #(
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 128,
  parameter int unsigned          VLEN      = 4096,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 trigger_i,
  output logic                 axi_req_valid,
  output logic [AddrWidth-1:0] axi_req,
  input  logic                 axi_resp_valid,
  input  logic [DataWidth-1:0] axi_resp
);
  localparam logic [AddrWidth-1:0] RowBytes   = AddrWidth'(DataWidth / 8);
  localparam logic [AddrWidth-1:0] SweepBytes = AddrWidth'(VLEN / 8);

  logic [AddrWidth-1:0] offset_q, offset_d;
  logic [DataWidth-1:0] acc_q, acc_d;

  always_comb begin
    offset_d = offset_q;
    acc_d    = acc_q;
    if (trigger_i) begin
      offset_d = (offset_q + RowBytes == SweepBytes) ? '0 : offset_q + RowBytes;
    end
    if (axi_resp_valid) begin
      acc_d = acc_q ^ axi_resp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      offset_q <= '0;
      acc_q    <= '0;
    end else begin
      offset_q <= offset_d;
      acc_q    <= acc_d;
    end
  end

  assign axi_req_valid = trigger_i;
  assign axi_req       = BaseAddr + offset_q;
endmodule

// Ara vector core wrapper; only the load unit is modelled.
module ara_core #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned VLEN      = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 trigger_i,
  output logic                 req_valid_o,
  output logic [AddrWidth-1:0] req_addr_o,
  input  logic                 resp_valid_i,
  input  logic [DataWidth-1:0] resp_data_i
);
  ara_vlsu #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .VLEN      (VLEN),
    .BaseAddr  (AddrWidth'(64'h8000_0000))
  ) i_vlsu (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .trigger_i      (trigger_i),
    .axi_req_valid  (req_valid_o),
    .axi_req        (req_addr_o),
    .axi_resp_valid (resp_valid_i),
    .axi_resp       (resp_data_i)
  );
endmodule

// CVA6 stand-in: the three performance strobes the harness counts. They
// idle low; an external agent drives them when stalls are to be modelled.
module ara_cva6 (
  input logic clk_i,
  input logic rst_ni
);
  logic dcache_stall_q, dcache_stall_d;
  logic icache_stall_q, icache_stall_d;
  logic sb_full_q, sb_full_d;

  always_comb begin
    dcache_stall_d = dcache_stall_q;
    icache_stall_d = icache_stall_q;
    sb_full_d      = sb_full_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dcache_stall_q <= 1'b0;
      icache_stall_q <= 1'b0;
      sb_full_q      <= 1'b0;
    end else begin
      dcache_stall_q <= dcache_stall_d;
      icache_stall_q <= icache_stall_d;
      sb_full_q      <= sb_full_d;
    end
  end
endmodule

// CVA6 plus Ara.
module ara_system #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned VLEN      = 4096
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 trigger_i,
  output logic                 req_valid_o,
  output logic [AddrWidth-1:0] req_addr_o,
  input  logic                 resp_valid_i,
  input  logic [DataWidth-1:0] resp_data_i
);
  ara_cva6 i_ariane (
    .clk_i  (clk_i),
    .rst_ni (rst_ni)
  );

  ara_core #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .VLEN      (VLEN)
  ) i_ara (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .trigger_i    (trigger_i),
    .req_valid_o  (req_valid_o),
    .req_addr_o   (req_addr_o),
    .resp_valid_i (resp_valid_i),
    .resp_data_i  (resp_data_i)
  );
endmodule

// Software-visible control registers: counter enable, exit word, and a
// one-cycle event trigger on every change of the enable bit.
module ara_ctrl_registers (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] hw_cnt_en_o,
  output logic [63:0] exit_o,
  output logic        event_trigger_o
);
  logic [31:0] hw_cnt_en_q, hw_cnt_en_d;
  logic [63:0] exit_q, exit_d;
  logic        en_dly_q, en_dly_d;

  always_comb begin
    hw_cnt_en_d = hw_cnt_en_q;
    exit_d      = exit_q;
    en_dly_d    = hw_cnt_en_q[0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hw_cnt_en_q <= '0;
      exit_q      <= '0;
      en_dly_q    <= 1'b0;
    end else begin
      hw_cnt_en_q <= hw_cnt_en_d;
      exit_q      <= exit_d;
      en_dly_q    <= en_dly_d;
    end
  end

  assign hw_cnt_en_o     = hw_cnt_en_q;
  assign exit_o          = exit_q;
  assign event_trigger_o = hw_cnt_en_q[0] ^ en_dly_q;
endmodule

// Ara SoC stand-in.
module ara_soc #(
  parameter int unsigned NrLanes      = 4,
  parameter int unsigned VLEN         = 4096,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiRespDelay = 200
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  output logic [63:0]                exit_o,
  output logic [31:0]                hw_cnt_en_o,
  ara_test_harness_if.master         uart
);
  if (AxiDataWidth != 32 * NrLanes) begin : g_bad_width
    $error("AxiDataWidth must equal 32*NrLanes");
  end

  logic                    event_trigger;
  logic                    req_valid;
  logic [AxiAddrWidth-1:0] req_addr;
  logic                    dram_hit, rram_hit, dram_rvalid, rram_rvalid;
  logic [AxiDataWidth-1:0] dram_rdata, rram_rdata;

  ara_ctrl_registers i_ctrl_registers (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .hw_cnt_en_o     (hw_cnt_en_o),
    .exit_o          (exit_o),
    .event_trigger_o (event_trigger)
  );

  ara_system #(
    .AddrWidth (AxiAddrWidth),
    .DataWidth (AxiDataWidth),
    .VLEN      (VLEN)
  ) i_system (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .trigger_i    (event_trigger),
    .req_valid_o  (req_valid),
    .req_addr_o   (req_addr),
    .resp_valid_i (dram_rvalid | rram_rvalid),
    .resp_data_i  (dram_hit ? dram_rdata : rram_rdata)
  );

  ara_mem_model #(
    .AddrWidth (AxiAddrWidth),
    .DataWidth (AxiDataWidth),
    .RespDelay (AxiRespDelay),
    .Base      (AxiAddrWidth'(64'h8000_0000)),
    .Length    (AxiAddrWidth'(64'h4000_0000))
  ) i_dram (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_valid),
    .addr_i   (req_addr),
    .hit_o    (dram_hit),
    .rvalid_o (dram_rvalid),
    .rdata_o  (dram_rdata)
  );

  ara_mem_model #(
    .AddrWidth (AxiAddrWidth),
    .DataWidth (AxiDataWidth),
    .RespDelay (AxiRespDelay),
    .Base      (AxiAddrWidth'(64'h1000_0000)),
    .Length    (AxiAddrWidth'(64'h4000_0000))
  ) i_rram (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_valid),
    .addr_i   (req_addr),
    .hit_o    (rram_hit),
    .rvalid_o (rram_rvalid),
    .rdata_o  (rram_rdata)
  );

  // Console UART master. Idles unless an agent drives it; the last status
  // read is kept so firmware-style polling has somewhere to land.
  logic        uart_psel_q, uart_psel_d;
  logic        uart_penable_q, uart_penable_d;
  logic        uart_pwrite_q, uart_pwrite_d;
  logic [31:0] uart_paddr_q, uart_paddr_d;
  logic [31:0] uart_pwdata_q, uart_pwdata_d;
  logic [7:0]  uart_lsr_q, uart_lsr_d;

  always_comb begin
    uart_psel_d    = uart_psel_q;
    uart_penable_d = uart_penable_q;
    uart_pwrite_d  = uart_pwrite_q;
    uart_paddr_d   = uart_paddr_q;
    uart_pwdata_d  = uart_pwdata_q;
    uart_lsr_d     = uart_lsr_q;
    if (uart.psel && uart.penable && uart.pready && !uart.pwrite && !uart.pslverr) begin
      uart_lsr_d = uart.prdata[7:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      uart_psel_q    <= 1'b0;
      uart_penable_q <= 1'b0;
      uart_pwrite_q  <= 1'b0;
      uart_paddr_q   <= '0;
      uart_pwdata_q  <= '0;
      uart_lsr_q     <= '0;
    end else begin
      uart_psel_q    <= uart_psel_d;
      uart_penable_q <= uart_penable_d;
      uart_pwrite_q  <= uart_pwrite_d;
      uart_paddr_q   <= uart_paddr_d;
      uart_pwdata_q  <= uart_pwdata_d;
      uart_lsr_q     <= uart_lsr_d;
    end
  end

  assign uart.psel    = uart_psel_q;
  assign uart.penable = uart_penable_q;
  assign uart.pwrite  = uart_pwrite_q;
  assign uart.paddr   = uart_paddr_q;
  assign uart.pwdata  = uart_pwdata_q;
endmodule

// Console UART sink: zero-wait APB slave. LSR (0x14) always reports the
// transmitter idle so firmware never blocks; a THR (0x00) write latches
// the character and pulses tx_valid_q for the console printer.
module ara_uart_sink (
  input  logic               clk_i,
  input  logic               rst_i,
  ara_test_harness_if.slave  apb,
  output logic               tx_valid_o,
  output logic [7:0]         tx_char_o
);
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_char_q, tx_char_d;
  logic       thr_write;

  // Only the low byte of the address is decoded: the UART window is 256 B.
  assign thr_write = apb.psel && apb.penable && apb.pwrite && (apb.paddr[7:0] == 8'h00);

  always_comb begin
    tx_valid_d = thr_write;
    tx_char_d  = thr_write ? apb.pwdata[7:0] : tx_char_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_valid_q <= 1'b0;
      tx_char_q  <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_char_q  <= tx_char_d;
    end
  end

  assign apb.pready  = 1'b1;
  assign apb.pslverr = 1'b0;
  assign apb.prdata  = (!rst_i && apb.psel && !apb.pwrite && apb.paddr[7:0] == 8'h14)
                       ? 32'h0000_0060 : 32'h0;
  assign tx_valid_o  = tx_valid_q;
  assign tx_char_o   = tx_char_q;
endmodule

module ara_test_harness #(
  parameter int unsigned NrLanes      = 4,
  parameter int unsigned VLEN         = 4096,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 128,
  parameter int unsigned AxiRespDelay = 200
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [63:0] exit_o
);
  ara_test_harness_if uart_apb ();

  logic        rst_n;
  logic [31:0] hw_cnt_en;
  logic        tx_valid;
  logic [7:0]  tx_char;

  assign rst_n = ~rst_i;

  ara_soc #(
    .NrLanes      (NrLanes),
    .VLEN         (VLEN),
    .AxiAddrWidth (AxiAddrWidth),
    .AxiDataWidth (AxiDataWidth),
    .AxiRespDelay (AxiRespDelay)
  ) i_ara_soc (
    .clk_i       (clk_i),
    .rst_ni      (rst_n),
    .exit_o      (exit_o),
    .hw_cnt_en_o (hw_cnt_en),
    .uart        (uart_apb.master)
  );

  ara_uart_sink i_uart_sink (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .apb        (uart_apb.slave),
    .tx_valid_o (tx_valid),
    .tx_char_o  (tx_char)
  );

  // Counter index: 0 runtime, 1 D$ stall, 2 I$ stall, 3 scoreboard full.
  logic        en, en_rise, en_fall;
  logic        cnt_en_q, cnt_en_d;
  logic [3:0]  inc;
  logic [63:0] cnt_q [4];
  logic [63:0] cnt_d [4];
  logic [63:0] runtime_buf_q, runtime_buf_d;
  logic [63:0] dcache_stall_buf_q, dcache_stall_buf_d;
  logic [63:0] icache_stall_buf_q, icache_stall_buf_d;
  logic [63:0] sb_full_buf_q, sb_full_buf_d;

  // Stall strobes have no SoC port; they are taken from inside CVA6.
  assign en  = hw_cnt_en[0];
  assign inc = {i_ara_soc.i_system.i_ariane.sb_full_q,
                i_ara_soc.i_system.i_ariane.icache_stall_q,
                i_ara_soc.i_system.i_ariane.dcache_stall_q,
                1'b1};
  assign en_rise = en & ~cnt_en_q;
  assign en_fall = ~en & cnt_en_q;

  // The first enabled cycle restarts from zero and already counts itself,
  // so an N-cycle window ends with N in the runtime counter.
  always_comb begin
    cnt_en_d = en;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (en_rise) begin
        cnt_d[i] = {63'b0, inc[i]};
      end else if (en) begin
        cnt_d[i] = cnt_q[i] + {63'b0, inc[i]};
      end
    end
    runtime_buf_d      = en_fall ? cnt_q[0] : runtime_buf_q;
    dcache_stall_buf_d = en_fall ? cnt_q[1] : dcache_stall_buf_q;
    icache_stall_buf_d = en_fall ? cnt_q[2] : icache_stall_buf_q;
    sb_full_buf_d      = en_fall ? cnt_q[3] : sb_full_buf_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_en_q           <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      runtime_buf_q      <= '0;
      dcache_stall_buf_q <= '0;
      icache_stall_buf_q <= '0;
      sb_full_buf_q      <= '0;
    end else begin
      cnt_en_q           <= cnt_en_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      runtime_buf_q      <= runtime_buf_d;
      dcache_stall_buf_q <= dcache_stall_buf_d;
      icache_stall_buf_q <= icache_stall_buf_d;
      sb_full_buf_q      <= sb_full_buf_d;
    end
  end
endmodule

// File: tb/tb_ara_test_harness.sv
// Directed bench for ara_test_harness. SoC-side activity (counter enable,
// CVA6 stall strobes, exit word, UART master) is injected by overriding the
// stand-in SoC registers; expectations are hand-computed cycle counts.
module tb_ara_test_harness;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] exit_o;
  int          errors = 0;
  int          checks = 0;

  ara_test_harness_if mon ();

  ara_test_harness dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .exit_o (exit_o)
  );

  always #5 clk = ~clk;

  assign mon.paddr   = dut.uart_apb.paddr;
  assign mon.psel    = dut.uart_apb.psel;
  assign mon.penable = dut.uart_apb.penable;
  assign mon.pwrite  = dut.uart_apb.pwrite;
  assign mon.pwdata  = dut.uart_apb.pwdata;
  assign mon.prdata  = dut.uart_apb.prdata;
  assign mon.pready  = dut.uart_apb.pready;
  assign mon.pslverr = dut.uart_apb.pslverr;

  // Console printer for the UART sink.
  always @(negedge clk) begin
    if (dut.i_uart_sink.tx_valid_q === 1'b1)
      $display("[TB] console: %c", dut.i_uart_sink.tx_char_q);
  end

  task checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive enable and stall strobes for the next rising edge, then advance
  // to the following falling edge.
  task applyStimulus(input logic en, input logic dst, input logic ist, input logic sbf);
    if (en) force dut.i_ara_soc.i_ctrl_registers.hw_cnt_en_q = 32'd1;
    else    force dut.i_ara_soc.i_ctrl_registers.hw_cnt_en_q = 32'd0;
    if (dst) force dut.i_ara_soc.i_system.i_ariane.dcache_stall_q = 1'b1;
    else     force dut.i_ara_soc.i_system.i_ariane.dcache_stall_q = 1'b0;
    if (ist) force dut.i_ara_soc.i_system.i_ariane.icache_stall_q = 1'b1;
    else     force dut.i_ara_soc.i_system.i_ariane.icache_stall_q = 1'b0;
    if (sbf) force dut.i_ara_soc.i_system.i_ariane.sb_full_q = 1'b1;
    else     force dut.i_ara_soc.i_system.i_ariane.sb_full_q = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset held for 5 cycles.
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("reset_exit", exit_o, 64'd0);
    checkOutput("reset_runtime_buf", dut.runtime_buf_q, 64'd0);
    checkOutput("reset_dcache_buf", dut.dcache_stall_buf_q, 64'd0);
    checkOutput("reset_icache_buf", dut.icache_stall_buf_q, 64'd0);
    checkOutput("reset_sb_buf", dut.sb_full_buf_q, 64'd0);
    checkOutput("reset_uart_idle", {63'd0, dut.i_uart_sink.tx_valid_q}, 64'd0);
    rst = 1'b0;

    // 100-cycle window, D$ stall on 7 of them.
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, (i >= 10 && i < 17), 1'b0, 1'b0);
      if (i == 0) checkOutput("win_first_cycle", dut.cnt_q[0], 64'd1);
    end
    checkOutput("win_runtime_cnt", dut.cnt_q[0], 64'd100);
    checkOutput("win_buf_before_fall", dut.runtime_buf_q, 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("win_runtime_buf", dut.runtime_buf_q, 64'd100);
    checkOutput("win_dcache_buf", dut.dcache_stall_buf_q, 64'd7);
    checkOutput("win_icache_buf", dut.icache_stall_buf_q, 64'd0);
    checkOutput("win_sb_buf", dut.sb_full_buf_q, 64'd0);

    // Two windows: 50 cycles, 10-cycle gap, 20 cycles.
    repeat (50) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("two_first_buf", dut.runtime_buf_q, 64'd50);
    checkOutput("two_dcache_overwrite", dut.dcache_stall_buf_q, 64'd0);
    repeat (9) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("two_gap_hold_buf", dut.runtime_buf_q, 64'd50);
    checkOutput("two_gap_hold_cnt", dut.cnt_q[0], 64'd50);
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("two_restart_cnt", dut.cnt_q[0], 64'd20);
    checkOutput("two_buf_until_fall", dut.runtime_buf_q, 64'd50);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("two_second_buf", dut.runtime_buf_q, 64'd20);

    // Reset in the middle of a 30-cycle window, then a 40-cycle window.
    repeat (30) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("mid_icache_cnt", dut.cnt_q[2], 64'd30);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("mid_rst_runtime_cnt", dut.cnt_q[0], 64'd0);
    checkOutput("mid_rst_icache_cnt", dut.cnt_q[2], 64'd0);
    checkOutput("mid_rst_runtime_buf", dut.runtime_buf_q, 64'd0);
    checkOutput("mid_rst_en_dly", {63'd0, dut.cnt_en_q}, 64'd0);
    repeat (40) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_new_runtime_buf", dut.runtime_buf_q, 64'd40);
    checkOutput("mid_new_sb_buf", dut.sb_full_buf_q, 64'd40);
    checkOutput("mid_new_icache_buf", dut.icache_stall_buf_q, 64'd0);

    // Exit asserted in the same cycle the enable falls.
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    force dut.i_ara_soc.i_ctrl_registers.exit_q = 64'd1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("exit_pass", exit_o, 64'd1);
    checkOutput("exit_same_cycle_buf", dut.runtime_buf_q, 64'd5);
    force dut.i_ara_soc.i_ctrl_registers.exit_q = 64'd7;
    #1;
    checkOutput("exit_fail_word", exit_o, 64'd7);
    checkOutput("exit_tohost_code", {1'b0, exit_o[63:1]}, 64'd3);

    // UART: write 'A' to THR.
    force dut.i_ara_soc.uart_paddr_q   = 32'h0;
    force dut.i_ara_soc.uart_pwdata_q  = 32'h41;
    force dut.i_ara_soc.uart_pwrite_q  = 1'b1;
    force dut.i_ara_soc.uart_psel_q    = 1'b1;
    force dut.i_ara_soc.uart_penable_q = 1'b0;
    @(negedge clk);
    force dut.i_ara_soc.uart_penable_q = 1'b1;
    #1;
    checkOutput("uart_wr_pready", {63'd0, mon.pready}, 64'd1);
    checkOutput("uart_wr_pslverr", {63'd0, mon.pslverr}, 64'd0);
    @(negedge clk);
    checkOutput("uart_tx_valid", {63'd0, dut.i_uart_sink.tx_valid_q}, 64'd1);
    checkOutput("uart_tx_char", {56'd0, dut.i_uart_sink.tx_char_q}, 64'h41);

    // UART: read LSR.
    force dut.i_ara_soc.uart_pwrite_q  = 1'b0;
    force dut.i_ara_soc.uart_paddr_q   = 32'h14;
    force dut.i_ara_soc.uart_penable_q = 1'b0;
    @(negedge clk);
    force dut.i_ara_soc.uart_penable_q = 1'b1;
    #1;
    checkOutput("uart_lsr_prdata", {32'd0, mon.prdata}, 64'h60);
    checkOutput("uart_lsr_pready", {63'd0, mon.pready}, 64'd1);
    checkOutput("uart_read_no_tx", {63'd0, dut.i_uart_sink.tx_valid_q}, 64'd0);
    force dut.i_ara_soc.uart_paddr_q = 32'h8;
    #1;
    checkOutput("uart_other_prdata", {32'd0, mon.prdata}, 64'd0);

    // UART write during reset is ignored.
    @(negedge clk);
    rst = 1'b1;
    force dut.i_ara_soc.uart_paddr_q  = 32'h0;
    force dut.i_ara_soc.uart_pwdata_q = 32'h42;
    force dut.i_ara_soc.uart_pwrite_q = 1'b1;
    @(negedge clk);
    checkOutput("uart_reset_ignored", {63'd0, dut.i_uart_sink.tx_valid_q}, 64'd0);
    force dut.i_ara_soc.uart_psel_q    = 1'b0;
    force dut.i_ara_soc.uart_penable_q = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
